// File: rtl/mips_perf_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_perf_monitor: pipeline event counters with IDLE/RUN/DRAIN/DONE FSM. |
// | Optional PERF_SATURATE_EN: counters saturate instead of wrapping. Rev 1.0 |
// +--------------------------------------------------------------------------+
module mips_perf_monitor #(
  parameter int CNT_WIDTH    = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int OPC_WIDTH    = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 retire_valid,
  input  logic [OPC_WIDTH-1:0] retire_opcode,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 data_hazard,
  input  logic                 halt_seen,
  input  logic [3:0]           rd_sel,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic [1:0]           state_o,
  output logic                 done
);

  localparam int NUM_CNT = 10;
  localparam int DW      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DW-1:0]         drain_q, drain_d;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_CNT];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_CNT];
  logic [CNT_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [NUM_CNT-1:0]    cnt_inc;
  logic [31:0]           opc_ext;
  logic                  counting;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (halt_seen) begin
          drain_d = '0;
          state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(DRAIN_CYCLES - 1)) state_d = S_DONE;
        else                                  drain_d = drain_q + DW'(1);
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      drain_d = '0;
    end
  end

  // Index order matches the rd_sel map: cycles, retired, 5 classes, stalls, flushes, hazards.
  assign counting = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign opc_ext  = 32'(retire_opcode);

  always_comb begin
    cnt_inc    = '0;
    cnt_inc[0] = counting;
    cnt_inc[1] = counting && retire_valid;
    cnt_inc[2] = counting && retire_valid && (opc_ext <= 32'h05);
    cnt_inc[3] = counting && retire_valid && (opc_ext >= 32'h06) && (opc_ext <= 32'h0B);
    cnt_inc[4] = counting && retire_valid && (opc_ext >= 32'h0C) && (opc_ext <= 32'h0D);
    cnt_inc[5] = counting && retire_valid && (opc_ext >= 32'h0E) && (opc_ext <= 32'h11);
    cnt_inc[6] = counting && retire_valid && (opc_ext >= 32'h12);
    cnt_inc[7] = counting && stall;
    cnt_inc[8] = counting && flush;
    cnt_inc[9] = counting && data_hazard;
  end

  always_comb begin
    for (int k = 0; k < NUM_CNT; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clear) begin
        cnt_d[k] = '0;
      end else if (cnt_inc[k]) begin
`ifdef PERF_SATURATE_EN
        if (cnt_q[k] != '1) cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
`else
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
`endif
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (!clear && (rd_sel < 4'(NUM_CNT))) rd_data_d = cnt_q[rd_sel];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      drain_q   <= '0;
      rd_data_q <= '0;
      for (int k = 0; k < NUM_CNT; k++) cnt_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      rd_data_q <= rd_data_d;
      for (int k = 0; k < NUM_CNT; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign rd_data = rd_data_q;
  assign state_o = state_q;
  assign done    = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mips_perf_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mips_perf_monitor: table-driven and scoreboard checks of the monitor. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mips_perf_monitor;

  logic        clk = 1'b0;
  logic        reset, start, clear, retire_valid, stall, flush, data_hazard, halt_seen;
  logic [5:0]  retire_opcode;
  logic [3:0]  rd_sel;
  logic [31:0] rd_data;
  logic [1:0]  state_o;
  logic        done;
  logic [3:0]  n_rd_data;
  logic [1:0]  n_state;
  logic        n_done;
  logic [31:0] z_rd_data;
  logic [1:0]  z_state;
  logic        z_done;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic       st;
    logic       rv;
    logic [5:0] opc;
    logic       stl;
    logic       fl;
    logic       hz;
    logic       ht;
    logic [1:0] exp_state;
  } vec_t;

  vec_t        tbl[20];
  logic [5:0]  ops[5]      = '{6'h00, 6'h07, 6'h0C, 6'h0E, 6'h3F};
  logic [5:0]  bops[6]     = '{6'h05, 6'h06, 6'h0B, 6'h0D, 6'h11, 6'h12};
  logic [31:0] exp_cnt[16] = '{32'd14, 32'd10, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2,
                               32'd5, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
`ifdef PERF_SATURATE_EN
  localparam logic [31:0] NARROW_EXP = 32'd15;
`else
  localparam logic [31:0] NARROW_EXP = 32'd4;
`endif

  always #5 clk = ~clk;

  mips_perf_monitor dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .retire_valid(retire_valid),
    .retire_opcode(retire_opcode), .stall(stall), .flush(flush), .data_hazard(data_hazard),
    .halt_seen(halt_seen), .rd_sel(rd_sel), .rd_data(rd_data), .state_o(state_o), .done(done)
  );

  mips_perf_monitor #(.CNT_WIDTH(4)) dut_n (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .retire_valid(retire_valid),
    .retire_opcode(retire_opcode), .stall(stall), .flush(flush), .data_hazard(data_hazard),
    .halt_seen(halt_seen), .rd_sel(rd_sel), .rd_data(n_rd_data), .state_o(n_state), .done(n_done)
  );

  mips_perf_monitor #(.DRAIN_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .retire_valid(retire_valid),
    .retire_opcode(retire_opcode), .stall(stall), .flush(flush), .data_hazard(data_hazard),
    .halt_seen(halt_seen), .rd_sel(rd_sel), .rd_data(z_rd_data), .state_o(z_state), .done(z_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in;
    start = 1'b0; clear = 1'b0; retire_valid = 1'b0; retire_opcode = 6'h00;
    stall = 1'b0; flush = 1'b0; data_hazard = 1'b0; halt_seen = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] sel, input logic [31:0] exp);
    rd_sel = sel;
    sb_q.push_back(exp);
    tick();
    chk(name, rd_data, sb_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < 20; i++) tbl[i] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[0].st = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tbl[i].rv  = 1'b1;
      tbl[i].opc = ops[(i - 1) % 5];
    end
    for (int i = 1; i <= 4; i++) tbl[i].stl = 1'b1;
    tbl[5].fl = 1'b1; tbl[6].fl = 1'b1;
    for (int i = 7; i <= 9; i++) tbl[i].hz = 1'b1;
    tbl[10].stl = 1'b1; tbl[10].fl = 1'b1; tbl[10].hz = 1'b1;
    tbl[11].ht = 1'b1;
    for (int i = 11; i <= 13; i++) tbl[i].exp_state = 2'd2;
    for (int i = 14; i <= 19; i++) tbl[i].exp_state = 2'd3;
    // DONE must ignore every event input, including a fresh start and halt.
    for (int i = 15; i <= 19; i++) begin
      tbl[i].st = 1'b1; tbl[i].rv = 1'b1; tbl[i].stl = 1'b1; tbl[i].ht = 1'b1;
    end

    idle_in();
    rd_sel = 4'd0;
    reset  = 1'b1;
    #3;
    chk("reset_state", state_o, 0);
    chk("reset_rd", rd_data, 0);
    chk("reset_done", done, 0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      start = tbl[i].st; retire_valid = tbl[i].rv; retire_opcode = tbl[i].opc;
      stall = tbl[i].stl; flush = tbl[i].fl; data_hazard = tbl[i].hz; halt_seen = tbl[i].ht;
      sb_q.push_back(32'(tbl[i].exp_state));
      tick();
      chk($sformatf("state_v%0d", i), state_o, sb_q.pop_front());
      chk($sformatf("done_v%0d", i), done, (tbl[i].exp_state == 2'd3));
      if (i == 11) chk("drain0_state", z_state, 3);
    end

    idle_in();
    for (int s = 0; s < 16; s++) rd_chk($sformatf("cnt_sel%0d", s), 4'(s), exp_cnt[s]);

    retire_valid = 1'b1; stall = 1'b1;
    for (int k = 0; k < 3; k++) rd_chk("done_hold", 4'd0, 32'd14);
    rd_sel = 4'd1;
    #1;
    chk("rd_latency", rd_data, 14);
    tick();
    chk("rd_after_sel", rd_data, 10);

    idle_in();
    clear = 1'b1; rd_sel = 4'd0;
    tick();
    chk("clear_state", state_o, 0);
    chk("clear_rd", rd_data, 0);
    clear = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; halt_seen = 1'b1;
    tick();
    halt_seen = 1'b0;
    tick();
    chk("drain_state", state_o, 2);
    chk("drain_rd", rd_data, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_state", state_o, 0);
    chk("async_rd", rd_data, 0);
    chk("async_done", done, 0);
    #1;
    reset = 1'b0;
    tick();
    tick();
    chk("post_reset_state", state_o, 0);
    chk("post_reset_rd", rd_data, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      retire_valid = 1'b1; retire_opcode = bops[k];
      tick();
    end
    idle_in();
    rd_chk("bnd_arith", 4'd2, 1);
    rd_chk("bnd_logic", 4'd3, 2);
    rd_chk("bnd_mem", 4'd4, 1);
    rd_chk("bnd_ctrl", 4'd5, 1);
    rd_chk("bnd_other", 4'd6, 1);
    rd_chk("bnd_retired", 4'd1, 6);
    clear = 1'b1; start = 1'b1;
    tick();
    chk("clr_start_state", state_o, 0);
    chk("clr_start_rd", rd_data, 0);
    idle_in();
    rd_chk("clr_retired", 4'd1, 0);
    rd_chk("clr_cycles", 4'd0, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 21; k++) tick();
    chk("wide_cycles", rd_data, 20);
    chk("narrow_cycles", n_rd_data, NARROW_EXP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
